// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//   Timebase and control stage for an MM:SS:cc stopwatch. The module divides
//   the board clock down to TICKS_PER_SEC ticks per second. A start/pause/clear
//   FSM, driven by raw key inputs, gates that timebase. It produces an
//   elapsed-tick count that wraps at 60 minutes, so the downstream decoder
//   digits stay in 0-9.
//
//   Optional feature (compile-time macro LAP_HOLD_EN):
//     A lap key freezes the displayed count on a hold register. The internal
//     counter keeps running while the display is frozen. Without the macro,
//     key_lap is ignored and no hold register is built.
//
// Ports
//   clk        in   1        system clock
//   rst        in   1        synchronous, active-high reset
//   key_start  in   1        raw start/pause key (async level)
//   key_clear  in   1        raw clear key (async level)
//   key_lap    in   1        raw lap key (async level, LAP_HOLD_EN only)
//   count      out  COUNT_W  ticks to display
//   hex_num    out  7        constant TICKS_PER_SEC for the decoder
//   running    out  1        registered, high while the FSM is in RUN
//   wrap       out  1        one-cycle pulse when count wraps MAX->0
// -----------------------------------------------------------------------------
module stopwatch_counter #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned COUNT_W       = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_start,
  input  logic               key_clear,
  input  logic               key_lap,
  output logic [COUNT_W-1:0] count,
  output logic [6:0]         hex_num,
  output logic               running,
  output logic               wrap
);

  localparam logic [31:0]        DIV_M1  = 32'(CLK_HZ / TICKS_PER_SEC - 1);
  localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(3600 * TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        pre;
  logic [COUNT_W-1:0] live;

  // Key conditioning. Bit 0 is start and bit 1 is clear.
  logic [1:0] key_s1, key_s2, key_dly, key_edge;
  logic       start_edge, clear_edge, tick;

  assign hex_num = 7'(TICKS_PER_SEC);

  // Two flops resynchronise the async keys. A third flop remembers the
  // previous level, so a held key yields a single registered pulse.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment, so every flop samples
    // pre-edge values no matter what order the statements appear in.
    if (rst) begin
      // NOTE: the synchronizer and edge flops are cleared as well. If they were
      // not, a key held through reset would emit a spurious edge afterwards.
      key_s1   <= '0;
      key_s2   <= '0;
      key_dly  <= '0;
      key_edge <= '0;
    end else begin
      key_s1   <= {key_clear, key_start};
      key_s2   <= key_s1;
      key_dly  <= key_s2;
      key_edge <= key_s2 & ~key_dly;
    end
  end

  assign start_edge = key_edge[0];
  assign clear_edge = key_edge[1];
  assign tick       = (state == RUN) && (pre == DIV_M1);

  // Control FSM, prescaler and live counter share one sequential block.
  // Clear outranks everything else in the same cycle, including a start edge
  // and a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pre     <= '0;
      live    <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear_edge) begin
        state   <= IDLE;
        pre     <= '0;
        live    <= '0;
        running <= 1'b0;
      end else begin
        // The prescaler advances only in RUN. PAUSE keeps the partial tick,
        // so resuming loses no time.
        if (state == RUN) begin
          if (tick) begin
            pre <= '0;
            if (live == MAX_CNT) begin
              live <= '0;
              wrap <= 1'b1;
            end else begin
              live <= live + COUNT_W'(1);
            end
          end else begin
            pre <= pre + 32'd1;
          end
        end

        if (start_edge) begin
          unique case (state)
            IDLE:    begin state <= RUN;   running <= 1'b1; end
            RUN:     begin state <= PAUSE; running <= 1'b0; end
            PAUSE:   begin state <= RUN;   running <= 1'b1; end
            default: begin state <= IDLE;  running <= 1'b0; end
          endcase
        end
      end
    end
  end

`ifdef LAP_HOLD_EN
  logic               lap_s1, lap_s2, lap_dly, lap_edge;
  logic               lap_mode;
  logic [COUNT_W-1:0] hold;

  // The first lap edge in RUN freezes the display. The next lap edge (in any
  // state) releases it. A clear edge always releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_s1   <= 1'b0;
      lap_s2   <= 1'b0;
      lap_dly  <= 1'b0;
      lap_edge <= 1'b0;
      lap_mode <= 1'b0;
      hold     <= '0;
    end else begin
      lap_s1   <= key_lap;
      lap_s2   <= lap_s1;
      lap_dly  <= lap_s2;
      lap_edge <= lap_s2 & ~lap_dly;
      if (clear_edge) begin
        lap_mode <= 1'b0;
      end else if (lap_edge) begin
        if (lap_mode) begin
          lap_mode <= 1'b0;
        end else if (state == RUN) begin
          lap_mode <= 1'b1;
          hold     <= live;
        end
      end
    end
  end

  assign count = lap_mode ? hold : live;
`else
  logic unused_key_lap;
  assign unused_key_lap = key_lap;
  assign count          = live;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter
//   Two instances share the same keys:
//     dut_a : CLK_HZ=1000, TICKS_PER_SEC=100 (DIV=10, MAX=359999)
//     dut_b : CLK_HZ=1,    TICKS_PER_SEC=1   (DIV=1,  MAX=3599), which reaches
//             its wrap quickly
//   The reference model tracks elapsed RUN clocks since the last clear or
//   reset. It derives each count as (run_clocks / DIV) mod (MAX+1). Key events
//   take effect on the fourth clock after the key is sampled high following a
//   low sample. The driver pushes one expectation per clock. An independent
//   monitor pops each expectation and compares it shortly after the clock edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter;

  localparam int DIV_A = 10;
  localparam int MOD_A = 360000;
  localparam int DIV_B = 1;
  localparam int MOD_B = 3600;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_start, key_clear, key_lap;
  logic [19:0] count_a, count_b;
  logic [6:0]  hex_a, hex_b;
  logic        running_a, running_b, wrap_a, wrap_b;

  always #5 clk = ~clk;

  stopwatch_counter #(.CLK_HZ(1000), .TICKS_PER_SEC(100), .COUNT_W(20)) dut_a (
    .clk(clk), .rst(rst), .key_start(key_start), .key_clear(key_clear),
    .key_lap(key_lap), .count(count_a), .hex_num(hex_a), .running(running_a),
    .wrap(wrap_a)
  );

  stopwatch_counter #(.CLK_HZ(1), .TICKS_PER_SEC(1), .COUNT_W(20)) dut_b (
    .clk(clk), .rst(rst), .key_start(key_start), .key_clear(key_clear),
    .key_lap(key_lap), .count(count_b), .hex_num(hex_b), .running(running_b),
    .wrap(wrap_b)
  );

  typedef struct {
    longint cnt_a;
    longint cnt_b;
    bit     run;
    bit     wrap_a;
    bit     wrap_b;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_t;
  mstate_t m_state;
  longint  run_clk;
  bit      lap_on;
  longint  hold_a, hold_b;
  // Recent sampled key levels; index i holds the level sampled i clocks ago.
  bit [4:1] h_start, h_clear, h_lap;

  task automatic model_step(input bit r, input bit s, input bit c, input bit l);
    exp_t e;
    bit   was_run, ev_s, ev_c, ev_l;
    e.wrap_a = 1'b0;
    e.wrap_b = 1'b0;
    if (r) begin
      m_state = M_IDLE;
      run_clk = 0;
      lap_on  = 1'b0;
      h_start = '0;
      h_clear = '0;
      h_lap   = '0;
    end else begin
      ev_s    = h_start[3] & ~h_start[4];
      ev_c    = h_clear[3] & ~h_clear[4];
      ev_l    = h_lap[3]   & ~h_lap[4];
      was_run = (m_state == M_RUN);
      if (ev_c) begin
        m_state = M_IDLE;
        run_clk = 0;
        lap_on  = 1'b0;
      end else begin
`ifdef LAP_HOLD_EN
        if (ev_l) begin
          if (lap_on) lap_on = 1'b0;
          else if (was_run) begin
            lap_on = 1'b1;
            hold_a = (run_clk / DIV_A) % MOD_A;
            hold_b = (run_clk / DIV_B) % MOD_B;
          end
        end
`endif
        if (was_run) begin
          run_clk++;
          e.wrap_a = (run_clk % (DIV_A * MOD_A)) == 0;
          e.wrap_b = (run_clk % (DIV_B * MOD_B)) == 0;
        end
        if (ev_s) begin
          case (m_state)
            M_IDLE:  m_state = M_RUN;
            M_RUN:   m_state = M_PAUSE;
            default: m_state = M_RUN;
          endcase
        end
      end
      h_start = {h_start[3:1], s};
      h_clear = {h_clear[3:1], c};
      h_lap   = {h_lap[3:1], l};
    end
    e.run   = (m_state == M_RUN);
    e.cnt_a = lap_on ? hold_a : (run_clk / DIV_A) % MOD_A;
    e.cnt_b = lap_on ? hold_b : (run_clk / DIV_B) % MOD_B;
    sb.push_back(e);
  endtask

  // Drive one clock's worth of inputs and queue the response expected after
  // the next rising edge.
  task automatic step(input bit r, input bit s, input bit c, input bit l);
    @(negedge clk);
    rst       = r;
    key_start = s;
    key_clear = c;
    key_lap   = l;
    model_step(r, s, c, l);
  endtask

  task automatic hold_for(input int n, input bit r, input bit s, input bit c, input bit l);
    for (int i = 0; i < n; i++) step(r, s, c, l);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("count_a", count_a, e.cnt_a);
        check("count_b", count_b, e.cnt_b);
        check("running_a", running_a, e.run);
        check("running_b", running_b, e.run);
        check("wrap_a", wrap_a, e.wrap_a);
        check("wrap_b", wrap_b, e.wrap_b);
        check("hex_a", hex_a, 100);
        check("hex_b", hex_b, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int s_left, c_left, l_left;
    bit s_lvl, c_lvl, l_lvl, r_now;
    rst = 1'b1; key_start = 1'b0; key_clear = 1'b0; key_lap = 1'b0;
    m_state = M_IDLE; run_clk = 0; lap_on = 1'b0; hold_a = 0; hold_b = 0;
    h_start = '0; h_clear = '0; h_lap = '0;

    hold_for(3, 1, 0, 0, 0);

    // Start held for 5 clocks, then run for 520 clocks.
    hold_for(5, 0, 1, 0, 0);
    hold_for(520, 0, 0, 0, 0);

    // Pause, wait, resume.
    hold_for(2, 0, 1, 0, 0);
    hold_for(100, 0, 0, 0, 0);
    hold_for(1, 0, 1, 0, 0);
    hold_for(60, 0, 0, 0, 0);

    // Pause, then start and clear rise together.
    hold_for(1, 0, 1, 0, 0);
    hold_for(10, 0, 0, 0, 0);
    hold_for(3, 0, 1, 1, 0);
    hold_for(10, 0, 0, 0, 0);
    hold_for(1, 0, 1, 0, 0);
    hold_for(60, 0, 0, 0, 0);

    // Reset in the middle of a run, then restart.
    hold_for(1, 1, 0, 0, 0);
    hold_for(5, 0, 0, 0, 0);
    hold_for(1, 0, 1, 0, 0);
    hold_for(300, 0, 0, 0, 0);

    // Lap press, long hold, lap release.
    hold_for(1, 0, 0, 0, 1);
    hold_for(200, 0, 0, 0, 0);
    hold_for(1, 0, 0, 0, 1);
    hold_for(30, 0, 0, 0, 0);

    // Clear, start, and run long enough for dut_b to wrap.
    hold_for(1, 0, 0, 1, 0);
    hold_for(8, 0, 0, 0, 0);
    hold_for(1, 0, 1, 0, 0);
    hold_for(4000, 0, 0, 0, 0);

    // Random key activity with occasional resets.
    s_left = 0; c_left = 1000; l_left = 0;
    s_lvl = 0;  c_lvl = 0;     l_lvl = 0;
    for (int i = 0; i < 15000; i++) begin
      if (s_left == 0) begin
        s_lvl  = ~s_lvl;
        s_left = s_lvl ? int'($urandom_range(6, 1)) : int'($urandom_range(1500, 20));
      end
      if (c_left == 0) begin
        c_lvl  = ~c_lvl;
        c_left = c_lvl ? int'($urandom_range(4, 1)) : int'($urandom_range(5000, 400));
      end
      if (l_left == 0) begin
        l_lvl  = ~l_lvl;
        l_left = l_lvl ? int'($urandom_range(4, 1)) : int'($urandom_range(800, 50));
      end
      r_now = ($urandom_range(7999, 0) == 0);
      step(r_now, s_lvl, c_lvl, l_lvl);
      s_left--; c_left--; l_left--;
    end

    hold_for(10, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
